// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD up/down counter with a bounded MSD, sync clear/load, wrap pulse and optional one-shot stop.
// Latency 1 clock per step; there is no backpressure, start simply gates stepping.
module bcd_counter_multi #(
  parameter int DIGITS        = 2,
  parameter int TOP_DIGIT_MAX = 5,
  parameter int ONE_SHOT      = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   values,
  output logic                  wrap,
  output logic                  done,
  output logic                  load_err
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;
  localparam logic [3:0] MSD_MAX = 4'(TOP_DIGIT_MAX);

  function automatic logic [3:0] dig_max(input int i);
    return (i == DIGITS - 1) ? MSD_MAX : 4'd9;
  endfunction

  logic [4*DIGITS-1:0] values_q, values_d;
  logic                wrap_q, wrap_d;
  logic                load_err_q, load_err_d;
  logic [0:0]          state_q, state_d;

  logic [4*DIGITS-1:0] step_val;
  logic [4*DIGITS-1:0] load_fix;
  logic [4*DIGITS-1:0] max_val;
  logic                step_carry;
  logic                load_bad;
  logic                step_hits_term;

  // Ripple carry/borrow across digits; a carry out of the MSD means we started at the terminal value.
  always_comb begin
    logic [3:0] d;
    logic [3:0] ld;
    logic       carry;
    d        = '0;
    ld       = '0;
    carry    = 1'b1;
    step_val = values_q;
    load_fix = '0;
    max_val  = '0;
    load_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d = values_q[4*i +: 4];
      max_val[4*i +: 4] = dig_max(i);
      if (carry) begin
        if (up) begin
          if (d == dig_max(i)) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            step_val[4*i +: 4] = dig_max(i);
          end else begin
            step_val[4*i +: 4] = d - 4'd1;
            carry = 1'b0;
          end
        end
      end
      ld = load_val[4*i +: 4];
      if (ld > dig_max(i)) begin
        load_bad = 1'b1;
      end else begin
        load_fix[4*i +: 4] = ld;
      end
    end
    step_carry     = carry;
    step_hits_term = up ? (step_val == max_val) : (step_val == '0);
  end

  always_comb begin
    values_d   = values_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    state_d    = state_q;
    if (clear) begin
      values_d = '0;
      state_d  = ST_RUN;
    end else if (load) begin
      values_d   = load_fix;
      load_err_d = load_bad;
      state_d    = ST_RUN;
    end else if (start && (state_q == ST_RUN)) begin
      if (ONE_SHOT != 0) begin
        // Already sitting on the terminal value: stop in place instead of wrapping.
        if (step_carry) begin
          state_d = ST_DONE;
        end else begin
          values_d = step_val;
          if (step_hits_term) begin
            state_d = ST_DONE;
            wrap_d  = 1'b1;
          end
        end
      end else begin
        values_d = step_val;
        wrap_d   = step_carry;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      values_q   <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      state_q    <= ST_RUN;
    end else begin
      values_q   <= values_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
      state_q    <= state_d;
    end
  end

  assign values   = values_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign done     = (state_q == ST_DONE);

endmodule
